seg_scan_driver: RTL

- Parametrised, time-multiplexed seven-segment display driver for a common-anode board display.
- Scans NUM_DIGITS digits, hex-decodes a 4-bit value per digit, and drives active-low segment, decimal-point and anode lines.
- Adds per-digit blanking, per-digit blinking, a load-strobed shadow register and an anti-ghosting gap.
- Sits between user logic (switches, counters, FSMs) and the board display pins.

---
 rtl/seg_scan_driver.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: scans NUM_DIGITS digits from a
// load-strobed shadow register with blanking, blinking and a dark gap at each slot start.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_TICKS  = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int TICK_W  = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [3:0] digit_arr [NUM_DIGITS];
  logic       tick_wrap;
  logic       idx_wrap;
  logic       frame_end;
  logic       dark;
  logic [3:0] cur_digit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = digits_q[4*gi +: 4];
    end
  endgenerate

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick_wrap = (tick_cnt_q == TICK_LAST);
    idx_wrap  = (idx_q == IDX_LAST);
    frame_end = tick_wrap && idx_wrap;

    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
    idx_d      = idx_q;
    if (tick_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
    end

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end

    digits_d = load ? digits_in : digits_q;
    dp_sh_d  = load ? dp_in     : dp_sh_q;
    blank_d  = load ? blank_in  : blank_q;
    blink_d  = load ? blink_in  : blink_q;
  end

  // Output stage works from pre-edge state, so the display trails the counters by one cycle.
  always_comb begin
    cur_digit    = digit_arr[idx_q];
    dark         = blank_q[idx_q] || (blink_q[idx_q] && blink_phase_q);
    an_d         = '1;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;
    frame_tick_d = frame_end;
    if ((tick_cnt_q != '0) && !dark) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex_to_seg(cur_digit);
      dp_d  = ~dp_sh_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q    <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digits_q      <= '0;
      dp_sh_q       <= '0;
      blank_q       <= '0;
      blink_q       <= '0;
      an_q          <= '1;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      digits_q      <= digits_d;
      dp_sh_q       <= dp_sh_d;
      blank_q       <= blank_d;
      blink_q       <= blink_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
